imm_extend_pipe: RTL and testbench

- Parametrised, pipelined immediate/operand extender for the MIPS32 datapath.
- Successor to the fixed 16->32 sign extender; generalised in width and extension mode.
- Adds a valid/ready handshake and a 2-entry skid buffer so it can sit between decode and execute without combinational ready paths.
- Supported modes: sign-extend, zero-extend, upper placement (lui), and sign-extend-shift-by-2 (branch offsets).

---
 rtl/imm_extend_pipe_if.sv | 24 ++
 rtl/imm_extend_pipe.sv | 100 ++++++++++
 tb/tb_imm_extend_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream valid/ready/immediate/mode
// and downstream valid/ready/data, seen from the producer (master) or the extender (slave).
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/sign-shift-2) with a 2-entry skid buffer.
// Optional accepted-transfer counter on xfer_cnt when IMM_EXT_CNT_EN is defined.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  localparam int PAD = OUT_W - IN_W;

  if (IN_W < 2 || IN_W > OUT_W - 2 || CNT_W < 1) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W/CNT_W combination");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic [OUT_W-1:0] main_q;
  logic [OUT_W-1:0] skid_q;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic             accept;
  logic             pop;

  assign sext = {{PAD{bus.in_imm[IN_W-1]}}, bus.in_imm};

  always_comb begin
    ext = '0;
    case (bus.in_mode)
      2'b00:   ext = sext;
      2'b01:   ext = {{PAD{1'b0}}, bus.in_imm};
      2'b10:   ext = {bus.in_imm, {PAD{1'b0}}};
      default: ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // Ready depends on occupancy only, so out_ready never reaches in_ready combinationally.
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_q;

  assign accept = bus.in_valid && (state != TWO);
  assign pop    = bus.out_ready && (state != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= ext;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= ext;
          end else if (accept) begin
            state  <= TWO;
            skid_q <= ext;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef IMM_EXT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (accept && !flush) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: queue-based occupancy/ordering model,
// directed mode/backpressure/flush/reset/counter cases, then randomized traffic.
module tb_imm_extend_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef IMM_EXT_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
`ifdef IMM_EXT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension from the arithmetic meaning of each mode.
  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint     v;
    logic [63:0] r;
    v = longint'(imm);
    if (imm[15]) v = v - 65536;
    case (mode)
      2'd0:    r = v;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * 65536;
      default: r = v * 4;
    endcase
    return r[31:0];
  endfunction

  logic [31:0] mq[$];
  logic [31:0] m_last;
  int          m_cnt;
  bit          m_acc, m_pop;
  logic [31:0] seen[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      m_acc = bus.in_valid && (mq.size() < 2);
      m_pop = bus.out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          mq.push_back(model_ext(bus.in_imm, bus.in_mode));
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
      chk("out_data", bus.out_data, m_last);
`ifdef IMM_EXT_CNT_EN
      chk("xfer_cnt", {28'd0, xfer_cnt}, m_cnt);
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) seen.push_back(bus.out_data);
  end

  task automatic send(input logic [15:0] imm, input logic [1:0] mode);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=stalled required=accept within 50 cycles");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] mode_exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
`ifdef IMM_EXT_CNT_EN
    chk("rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
    @(negedge clk); #2;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Mode coverage, one cycle after accept
    for (int m = 0; m < 4; m++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_imm    = 16'h8001;
      bus.in_mode   = 2'(m);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("mode%0d_data", m), bus.out_data, mode_exp[m]);
      chk($sformatf("mode%0d_valid", m), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("model_mode%0d", m), model_ext(16'h8001, 2'(m)), mode_exp[m]);
    end

    // Backpressure: A,B buffered, C held
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    seen.delete();
    send(16'h1234, 2'd1);
    send(16'hFFFF, 2'd0);
    bus.in_imm  = 16'h0001;
    bus.in_mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0001, 2'd3);
    bus.in_valid = 1'b0;
    idle_cycles(4);
    chk("bp_count", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      chk("bp_A", seen[0], 32'h00001234);
      chk("bp_B", seen[1], 32'hFFFFFFFF);
      chk("bp_C", seen[2], 32'h00000004);
    end

    // Streaming: one result per cycle, in_ready never drops
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_imm   = 16'($urandom);
      bus.in_mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    idle_cycles(2);
    chk("stream_count", seen.size(), 32'd8);

    // Flush while full with a word presented
    bus.out_ready = 1'b0;
    send(16'h00A5, 2'd1);
    send(16'h0F0F, 2'd1);
    seen.delete();
    bus.in_imm  = 16'h7777;
    bus.in_mode = 2'd0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("flush_out_data_kept", bus.out_data, 32'h000000A5);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle_cycles(3);
    chk("flush_nothing_delivered", seen.size(), 32'd0);

    // Asynchronous reset between edges
    bus.out_ready = 1'b0;
    send(16'h4321, 2'd2);
    send(16'h1111, 2'd0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef IMM_EXT_CNT_EN
    // Counter wrap after 17 accepts with CNT_W=4
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(16'(i), 2'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_wrap", {28'd0, xfer_cnt}, 32'd1);
    @(posedge clk); #1;
`endif

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_imm    = 16'($urandom);
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
